dsp_mac_pipe: RTL and testbench

- Parametrised, pipelined multiply-accumulate slice. Next generation of the team's DSP48A1-style slice.
- Datapath: pre-adder/subtractor, signed multiplier, post-adder/subtractor with Z-mux (zero / C / own accumulator / cascade PCIN).
- Adds valid/first/last framing for streaming accumulation, plus a global clock enable and an overflow flag.
- Instances chain through bcout/pcout to form FIR/dot-product columns.

---
 rtl/dsp_mac_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Three-stage pipelined pre-add / multiply / post-add MAC slice with valid/first/last framing.
// Build option: define DSP_SAT_EN to clamp P on overflow instead of wrapping.
module dsp_mac_pipe #(
    parameter int A_W = 18,
    parameter int B_W = 18,
    parameter int C_W = 48,
    parameter int P_W = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    input  logic [B_W-1:0]       bcin,
    input  logic [B_W-1:0]       d,
    input  logic [C_W-1:0]       c,
    input  logic [P_W-1:0]       pcin,
    input  logic [5:0]           opmode,
    output logic [B_W-1:0]       bcout,
    output logic [A_W+B_W-1:0]   m,
    output logic [P_W-1:0]       p,
    output logic [P_W-1:0]       pcout,
    output logic                 p_valid,
    output logic                 p_last,
    output logic                 ovf
);

    localparam int M_W = A_W + B_W;
    localparam int S_W = P_W + 1;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_C    = 2'd1,
        Z_P    = 2'd2,
        Z_PCIN = 2'd3
    } z_sel_e;

    // Stage 1 registers
    logic signed [A_W-1:0] a1_q, a1_d;
    logic signed [B_W-1:0] b1_q, b1_d;
    logic signed [B_W-1:0] d1_q, d1_d;
    logic signed [C_W-1:0] c1_q, c1_d;
    logic                  use_pre1_q, use_pre1_d;
    logic                  pre_sub1_q, pre_sub1_d;
    z_sel_e                z_sel1_q, z_sel1_d;
    logic                  post_sub1_q, post_sub1_d;
    logic                  v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;

    // Stage 2 registers
    logic signed [M_W-1:0] m2_q, m2_d;
    logic signed [C_W-1:0] c2_q, c2_d;
    z_sel_e                z_sel2_q, z_sel2_d;
    logic                  post_sub2_q, post_sub2_d;
    logic                  v2_q, v2_d, f2_q, f2_d, l2_q, l2_d;

    // Stage 3 registers
    logic signed [P_W-1:0] p3_q, p3_d;
    logic                  ovf3_q, ovf3_d;
    logic                  pv3_q, pv3_d;
    logic                  pl3_q, pl3_d;

    // Combinational datapath
    logic signed [B_W-1:0] pre;
    logic signed [M_W-1:0] prod;
    logic signed [S_W-1:0] x_ext, z_ext, sum;
    logic                  sum_ovf;
    logic signed [P_W-1:0] p_res;

    // NOTE: every variable assigned in an always_comb gets a default first so no
    // path leaves it unassigned; that is what keeps these blocks free of latches.
    always_comb begin
        pre = b1_q;
        if (use_pre1_q) begin
            pre = pre_sub1_q ? (d1_q - b1_q) : (d1_q + b1_q);
        end
        prod = M_W'(a1_q) * M_W'(pre);
    end

    always_comb begin
        x_ext = S_W'(m2_q);
        z_ext = '0;
        case (z_sel2_q)
            Z_C:     z_ext = S_W'(c2_q);
            Z_P:     z_ext = S_W'(p3_q);
            Z_PCIN:  z_ext = S_W'($signed(pcin));
            default: z_ext = '0;
        endcase
        if (f2_q) begin
            z_ext = '0;
        end
        sum     = post_sub2_q ? (z_ext - x_ext) : (z_ext + x_ext);
        // One guard bit is enough: |X| < 2^(P_W-2), so the true result fits in P_W+1 bits.
        sum_ovf = sum[S_W-1] ^ sum[S_W-2];
        p_res   = sum[P_W-1:0];
`ifdef DSP_SAT_EN
        if (sum_ovf) begin
            p_res = sum[S_W-1] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        a1_d        = a1_q;
        b1_d        = b1_q;
        d1_d        = d1_q;
        c1_d        = c1_q;
        use_pre1_d  = use_pre1_q;
        pre_sub1_d  = pre_sub1_q;
        z_sel1_d    = z_sel1_q;
        post_sub1_d = post_sub1_q;
        v1_d        = v1_q;
        f1_d        = f1_q;
        l1_d        = l1_q;
        m2_d        = m2_q;
        c2_d        = c2_q;
        z_sel2_d    = z_sel2_q;
        post_sub2_d = post_sub2_q;
        v2_d        = v2_q;
        f2_d        = f2_q;
        l2_d        = l2_q;
        p3_d        = p3_q;
        ovf3_d      = ovf3_q;
        pv3_d       = pv3_q;
        pl3_d       = pl3_q;
        if (ce) begin
            a1_d        = $signed(a);
            b1_d        = opmode[0] ? $signed(bcin) : $signed(b);
            d1_d        = $signed(d);
            c1_d        = $signed(c);
            use_pre1_d  = opmode[1];
            pre_sub1_d  = opmode[2];
            z_sel1_d    = z_sel_e'(opmode[4:3]);
            post_sub1_d = opmode[5];
            v1_d        = in_valid;
            f1_d        = in_first;
            l1_d        = in_last;

            m2_d        = prod;
            c2_d        = c1_q;
            z_sel2_d    = z_sel1_q;
            post_sub2_d = post_sub1_q;
            v2_d        = v1_q;
            f2_d        = f1_q;
            l2_d        = l1_q;

            pv3_d       = v2_q;
            pl3_d       = v2_q & l2_q;
            // P only moves on a valid result, so gaps leave the accumulator intact.
            if (v2_q) begin
                p3_d   = p_res;
                ovf3_d = sum_ovf;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q        <= '0;
            b1_q        <= '0;
            d1_q        <= '0;
            c1_q        <= '0;
            use_pre1_q  <= 1'b0;
            pre_sub1_q  <= 1'b0;
            z_sel1_q    <= Z_ZERO;
            post_sub1_q <= 1'b0;
            v1_q        <= 1'b0;
            f1_q        <= 1'b0;
            l1_q        <= 1'b0;
            m2_q        <= '0;
            c2_q        <= '0;
            z_sel2_q    <= Z_ZERO;
            post_sub2_q <= 1'b0;
            v2_q        <= 1'b0;
            f2_q        <= 1'b0;
            l2_q        <= 1'b0;
            p3_q        <= '0;
            ovf3_q      <= 1'b0;
            pv3_q       <= 1'b0;
            pl3_q       <= 1'b0;
        end else begin
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            d1_q        <= d1_d;
            c1_q        <= c1_d;
            use_pre1_q  <= use_pre1_d;
            pre_sub1_q  <= pre_sub1_d;
            z_sel1_q    <= z_sel1_d;
            post_sub1_q <= post_sub1_d;
            v1_q        <= v1_d;
            f1_q        <= f1_d;
            l1_q        <= l1_d;
            m2_q        <= m2_d;
            c2_q        <= c2_d;
            z_sel2_q    <= z_sel2_d;
            post_sub2_q <= post_sub2_d;
            v2_q        <= v2_d;
            f2_q        <= f2_d;
            l2_q        <= l2_d;
            p3_q        <= p3_d;
            ovf3_q      <= ovf3_d;
            pv3_q       <= pv3_d;
            pl3_q       <= pl3_d;
        end
    end

    assign bcout   = b1_q;
    assign m       = m2_q;
    assign p       = p3_q;
    assign pcout   = p3_q;
    assign p_valid = pv3_q;
    assign p_last  = pl3_q;
    assign ovf     = ovf3_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe: directed scenarios plus randomized traffic
// scored against an in-order arithmetic model of the slice.
module tb_dsp_mac_pipe;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int C_W = 48;
    localparam int P_W = 48;
    localparam longint P_MAX = (64'sd1 <<< (P_W - 1)) - 64'sd1;
    localparam longint P_MIN = -(64'sd1 <<< (P_W - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ce = 1'b1;
    logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic signed [A_W-1:0] a = '0;
    logic signed [B_W-1:0] b = '0, bcin = '0, d = '0;
    logic signed [C_W-1:0] c = '0;
    logic signed [P_W-1:0] pcin = '0;
    logic [5:0] opmode = '0;
    logic [B_W-1:0] bcout;
    logic [A_W+B_W-1:0] m;
    logic [P_W-1:0] p, pcout;
    logic p_valid, p_last, ovf;

    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .P_W(P_W)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .a(a), .b(b), .bcin(bcin), .d(d), .c(c), .pcin(pcin),
        .opmode(opmode), .bcout(bcout), .m(m), .p(p), .pcout(pcout),
        .p_valid(p_valid), .p_last(p_last), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    longint en_edges = 0;

    typedef struct {
        longint p;
        bit     ovf;
        bit     last;
        longint due;
    } exp_t;

    exp_t   exp_q[$];
    longint obs_p[$];
    bit     obs_last[$];
    bit     obs_ovf[$];
    longint model_p = 0;

    function automatic longint sx(longint v, int w);
        longint t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    // One clock: score the sample on the inputs, advance, then compare any result.
    task automatic step();
        exp_t e;
        longint bv, pre, x, z, r, ep;
        bit ce_was;
        logic pv_before;
        ce_was = ce;
        if (ce && in_valid) begin
            bv  = opmode[0] ? longint'(bcin) : longint'(b);
            pre = opmode[1] ? sx(opmode[2] ? longint'(d) - bv : longint'(d) + bv, B_W) : bv;
            x   = longint'(a) * pre;
            case (opmode[4:3])
                2'd1:    z = longint'(c);
                2'd2:    z = model_p;
                2'd3:    z = longint'(pcin);
                default: z = 0;
            endcase
            if (in_first) z = 0;
            r = opmode[5] ? z - x : z + x;
            e.ovf = (r > P_MAX) || (r < P_MIN);
`ifdef DSP_SAT_EN
            e.p = (r > P_MAX) ? P_MAX : ((r < P_MIN) ? P_MIN : r);
`else
            e.p = sx(r, P_W);
`endif
            e.last  = in_last;
            e.due   = en_edges + 3;
            model_p = e.p;
            exp_q.push_back(e);
        end
        if (ce) en_edges++;
        pv_before = p_valid;
        @(posedge clk);
        #1;
        if (!ce_was) begin
            checks++;
            if (p_valid !== pv_before) begin
                errors++;
                $display("FAIL stall_hold: p_valid=%b required=%b", p_valid, pv_before);
            end
        end else if (p_valid === 1'b1) begin
            obs_p.push_back(longint'($signed(p)));
            obs_last.push_back(p_last);
            obs_ovf.push_back(ovf);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid: p_valid=1 p=%0d required no result", $signed(p));
            end else begin
                e  = exp_q.pop_front();
                ep = e.p;
                if (p !== ep[P_W-1:0] || pcout !== ep[P_W-1:0] || ovf !== e.ovf ||
                    p_last !== e.last || en_edges != e.due) begin
                    errors++;
                    $display("FAIL result: p=%0d pcout=%0d ovf=%b last=%b edge=%0d required p=%0d ovf=%b last=%b edge=%0d",
                             $signed(p), $signed(pcout), ovf, p_last, en_edges, e.p, e.ovf, e.last, e.due);
                end
            end
        end else begin
            checks++;
            if (p_valid !== 1'b0 || (exp_q.size() > 0 && exp_q[0].due <= en_edges)) begin
                errors++;
                $display("FAIL missing_valid: p_valid=%b at edge %0d required 1", p_valid, en_edges);
            end
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        ce       = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_obs();
        obs_p.delete();
        obs_last.delete();
        obs_ovf.delete();
    endtask

    task automatic test_reset();
        ce = 1'b1; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        a = 5; b = 7; bcin = 3; d = 9; c = 11; pcin = 13; opmode = 6'b101011;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bcout, m, p, pcout, p_valid, p_last, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_async: bcout=%0d m=%0d p=%0d pcout=%0d pv=%b pl=%b ovf=%b required all 0",
                     bcout, m, p, pcout, p_valid, p_last, ovf);
        end
        ce = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bcout, m, p, p_valid} !== '0) begin
            errors++;
            $display("FAIL reset_hold: bcout=%0d m=%0d p=%0d pv=%b required all 0", bcout, m, p, p_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        a = 0; b = 0; bcin = 0; d = 0; c = 0; pcin = 0; opmode = '0;
        exp_q.delete();
        model_p = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (p_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: p_valid=%b cycle %0d required 0", p_valid, i);
            end
        end
    endtask

    task automatic test_mul_c();
        a = 10; b = 20; c = 30; d = 0; opmode = 6'b001000;
        in_valid = 1'b1; in_first = 1'b0; in_last = 1'b0;
        step();
        checks++;
        if (bcout !== 18'd20) begin
            errors++;
            $display("FAIL mul_c_bcout: bcout=%0d required 20", bcout);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (m !== 36'd200) begin
            errors++;
            $display("FAIL mul_c_m: m=%0d required 200", m);
        end
        step();
        checks++;
        if (p_valid !== 1'b1 || p !== 48'd230) begin
            errors++;
            $display("FAIL mul_c_p: p=%0d p_valid=%b required 230 and 1", $signed(p), p_valid);
        end
        step();
        checks++;
        if (p_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_c_pulse: p_valid=%b required 0", p_valid);
        end
    endtask

    task automatic test_pre_sub();
        logic [5:0] opm[3];
        longint expv[3];
        opm[0] = 6'b000010; expv[0] = 600;
        opm[1] = 6'b000110; expv[1] = 200;
        opm[2] = 6'b101010; expv[2] = -570;
        for (int i = 0; i < 3; i++) begin
            a = 10; b = 20; d = 40; c = 30; opmode = opm[i];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            step();
            checks++;
            if (p_valid !== 1'b1 || p !== 48'(expv[i])) begin
                errors++;
                $display("FAIL pre_sub_%0d: p=%0d p_valid=%b required %0d and 1", i, $signed(p), p_valid, expv[i]);
            end
            step();
        end
    endtask

    task automatic test_accum_frame(input bit stall);
        clear_obs();
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 4; s++) begin
                a = 10; b = 20; opmode = 6'b010000;
                in_valid = 1'b1; in_first = (s == 0); in_last = (s == 3);
                step();
                if (stall && f == 0 && s == 1) begin
                    ce = 1'b0;
                    step();
                    step();
                    ce = 1'b1;
                end
            end
        end
        idle_inputs();
        drain();
        checks++;
        if (obs_p.size() != 8) begin
            errors++;
            $display("FAIL accum_count stall=%0d: results=%0d required 8", stall, obs_p.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_p[i] != 200 * (i % 4 + 1) || obs_last[i] != (i % 4 == 3)) begin
                    errors++;
                    $display("FAIL accum_%0d stall=%0d: p=%0d last=%b required %0d last=%b",
                             i, stall, obs_p[i], obs_last[i], 200 * (i % 4 + 1), (i % 4 == 3));
                end
            end
        end
    endtask

    task automatic test_overflow();
        longint exp0;
`ifdef DSP_SAT_EN
        exp0 = P_MAX;
`else
        exp0 = P_MIN;
`endif
        clear_obs();
        a = 1; b = 1; d = 0; c = 48'(P_MAX); opmode = 6'b001000;
        in_valid = 1'b1; in_first = 1'b0; in_last = 1'b0;
        step();
        c = 0;
        step();
        idle_inputs();
        drain();
        checks++;
        if (obs_p.size() != 2) begin
            errors++;
            $display("FAIL ovf_count: results=%0d required 2", obs_p.size());
        end else begin
            checks++;
            if (obs_p[0] != exp0 || obs_ovf[0] != 1'b1) begin
                errors++;
                $display("FAIL ovf_first: p=%0d ovf=%b required %0d ovf=1", obs_p[0], obs_ovf[0], exp0);
            end
            checks++;
            if (obs_p[1] != 1 || obs_ovf[1] != 1'b0) begin
                errors++;
                $display("FAIL ovf_clear: p=%0d ovf=%b required 1 ovf=0", obs_p[1], obs_ovf[1]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        a = 3; b = 4; opmode = 6'b010000;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0;
        step();
        in_first = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (p_valid !== 1'b0 || p !== '0) begin
            errors++;
            $display("FAIL midframe_reset: p=%0d p_valid=%b required 0 and 0", $signed(p), p_valid);
        end
        exp_q.delete();
        model_p = 0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
    endtask

    task automatic test_random();
        pcin = 48'({$urandom(), $urandom()});
        for (int i = 0; i < 300; i++) begin
            ce       = ($urandom_range(0, 7) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_first = ($urandom_range(0, 5) == 0);
            in_last  = ($urandom_range(0, 5) == 0);
            a        = 18'($urandom());
            b        = 18'($urandom());
            bcin     = 18'($urandom());
            d        = 18'($urandom());
            c        = 48'({$urandom(), $urandom()});
            opmode   = 6'($urandom());
            step();
        end
        idle_inputs();
        drain();
    endtask

    initial begin
        test_reset();
        test_mul_c();
        test_pre_sub();
        test_accum_frame(1'b0);
        test_accum_frame(1'b1);
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
